// File: rtl/fadder_initiator_if.sv
// rtl/fadder_initiator_if.sv - command, response and adder-control bundle for fadder_initiator
// master is the initiator side; slave is the datapath controller plus adder side.
interface fadder_initiator_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_op;
  logic [DATA_WIDTH-1:0] cmd_a;
  logic [DATA_WIDTH-1:0] cmd_b;
  logic                  cmd_cin;
  logic                  cmd_chain;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_carry;
  logic                  rsp_err;
  logic [CNT_WIDTH-1:0]  op_count;

  logic                  fa_op;
  logic                  fa_ex;
  logic                  fa_vld_in;
  logic                  fa_carry_in;
  logic [DATA_WIDTH-1:0] fa_op_a;
  logic [DATA_WIDTH-1:0] fa_op_b;
  logic                  fa_vld_out;
  logic                  fa_carry_out;
  logic [DATA_WIDTH-1:0] fa_data_out;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_chain,
    output cmd_ready,
    output rsp_valid, rsp_data, rsp_carry, rsp_err, op_count,
    input  rsp_ready,
    output fa_op, fa_ex, fa_vld_in, fa_carry_in, fa_op_a, fa_op_b,
    input  fa_vld_out, fa_carry_out, fa_data_out
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_cin, cmd_chain,
    input  cmd_ready,
    input  rsp_valid, rsp_data, rsp_carry, rsp_err, op_count,
    output rsp_ready,
    input  fa_op, fa_ex, fa_vld_in, fa_carry_in, fa_op_a, fa_op_b,
    output fa_vld_out, fa_carry_out, fa_data_out
  );
endinterface

// File: rtl/fadder_initiator.sv
// rtl/fadder_initiator.sv - sequences add/subtract commands onto the adder load/execute port
// One command in flight: IDLE -> LOAD -> EXEC -> WAIT -> RESP, all outputs registered.
module fadder_initiator #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk,
  input logic               reset_n,
  fadder_initiator_if.master bus
);
  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_cmd_ready, w_cmd_ready_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_data, w_rsp_data_nxt;
  logic                  r_rsp_carry, w_rsp_carry_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic [CNT_WIDTH-1:0]  r_op_count, w_op_count_nxt;
  logic                  r_fa_op, w_fa_op_nxt;
  logic                  r_fa_ex, w_fa_ex_nxt;
  logic                  r_fa_vld_in, w_fa_vld_in_nxt;
  logic                  r_fa_carry_in, w_fa_carry_in_nxt;
  logic [DATA_WIDTH-1:0] r_fa_op_a, w_fa_op_a_nxt;
  logic [DATA_WIDTH-1:0] r_fa_op_b, w_fa_op_b_nxt;
  logic [WCW-1:0]        r_wait_cnt, w_wait_cnt_nxt;
  logic                  r_chain_carry, w_chain_carry_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_carry   <= 1'b0;
      r_rsp_err     <= 1'b0;
      r_op_count    <= '0;
      r_fa_op       <= 1'b0;
      r_fa_ex       <= 1'b0;
      r_fa_vld_in   <= 1'b0;
      r_fa_carry_in <= 1'b0;
      r_fa_op_a     <= '0;
      r_fa_op_b     <= '0;
      r_wait_cnt    <= '0;
      r_chain_carry <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cmd_ready   <= w_cmd_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_data    <= w_rsp_data_nxt;
      r_rsp_carry   <= w_rsp_carry_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_op_count    <= w_op_count_nxt;
      r_fa_op       <= w_fa_op_nxt;
      r_fa_ex       <= w_fa_ex_nxt;
      r_fa_vld_in   <= w_fa_vld_in_nxt;
      r_fa_carry_in <= w_fa_carry_in_nxt;
      r_fa_op_a     <= w_fa_op_a_nxt;
      r_fa_op_b     <= w_fa_op_b_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_chain_carry <= w_chain_carry_nxt;
    end
  end

  // Next values describe the outputs of the state being entered, so each output is a flop.
  always_comb begin
    w_state_nxt       = r_state;
    w_cmd_ready_nxt   = r_cmd_ready;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_data_nxt    = r_rsp_data;
    w_rsp_carry_nxt   = r_rsp_carry;
    w_rsp_err_nxt     = r_rsp_err;
    w_op_count_nxt    = r_op_count;
    w_fa_op_nxt       = r_fa_op;
    w_fa_ex_nxt       = 1'b0;
    w_fa_vld_in_nxt   = 1'b0;
    w_fa_carry_in_nxt = r_fa_carry_in;
    w_fa_op_a_nxt     = r_fa_op_a;
    w_fa_op_b_nxt     = r_fa_op_b;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_chain_carry_nxt = r_chain_carry;

    case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (bus.cmd_valid && r_cmd_ready) begin
          w_cmd_ready_nxt   = 1'b0;
          w_fa_op_nxt       = bus.cmd_op;
          w_fa_op_a_nxt     = bus.cmd_a;
          w_fa_op_b_nxt     = bus.cmd_b;
          w_fa_carry_in_nxt = bus.cmd_op & (bus.cmd_chain ? r_chain_carry : bus.cmd_cin);
          w_fa_vld_in_nxt   = 1'b1;
          w_state_nxt       = S_LOAD;
        end
      end
      S_LOAD: begin
        w_fa_ex_nxt = 1'b1;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_wait_cnt_nxt = '0;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.fa_vld_out) begin
          w_rsp_data_nxt    = bus.fa_data_out;
          w_rsp_carry_nxt   = bus.fa_carry_out;
          w_rsp_err_nxt     = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_chain_carry_nxt = r_fa_op & bus.fa_carry_out;
          w_state_nxt       = S_RESP;
        end else if (r_wait_cnt == TIMEOUT_W) begin
          // Error responses leave the chain carry untouched.
          w_rsp_data_nxt  = '0;
          w_rsp_carry_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_op_count_nxt  = r_op_count + 1'b1;
          w_cmd_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_carry   = r_rsp_carry;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.op_count    = r_op_count;
  assign bus.fa_op       = r_fa_op;
  assign bus.fa_ex       = r_fa_ex;
  assign bus.fa_vld_in   = r_fa_vld_in;
  assign bus.fa_carry_in = r_fa_carry_in;
  assign bus.fa_op_a     = r_fa_op_a;
  assign bus.fa_op_b     = r_fa_op_b;
endmodule

// File: tb/tb_fadder_initiator.sv
// tb/tb_fadder_initiator.sv - self-checking bench for fadder_initiator with a behavioural adder
// Table vectors plus hand sequences for backpressure, timeout and reset mid-operation.
module tb_fadder_initiator;
  localparam int DW = 8;
  localparam int TO = 15;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fadder_initiator_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  fadder_initiator #(.DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural adder following the load/execute contract; stub_dead hides vld_out.
  logic [DW-1:0] m_a, m_b, m_data;
  logic          m_cin, m_carry, m_vld;
  logic          stub_dead = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_a <= '0; m_b <= '0; m_cin <= 1'b0;
      m_data <= '0; m_carry <= 1'b0; m_vld <= 1'b0;
    end else begin
      if (!bus.fa_ex && bus.fa_vld_in) begin
        m_a <= bus.fa_op_a; m_b <= bus.fa_op_b; m_cin <= bus.fa_carry_in;
      end
      if (bus.fa_ex) begin
        if (bus.fa_op) {m_carry, m_data} <= 9'(m_a) + 9'(m_b) + 9'(m_cin);
        else begin
          m_data  <= m_a - m_b;
          m_carry <= (m_b > m_a);
        end
        m_vld <= 1'b1;
      end
    end
  end

  assign bus.fa_vld_out   = m_vld & ~stub_dead;
  assign bus.fa_carry_out = m_carry;
  assign bus.fa_data_out  = m_data;

  typedef struct {
    logic          op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cin;
    logic          chain;
    logic [DW-1:0] e_data;
    logic          e_carry;
    logic          e_err;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          carry;
    logic          err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;
  logic tb_cc   = 1'b0;
  logic ex_ex;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic cin, input logic chain, input logic [DW-1:0] d,
                              input logic c, input logic e);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cin = cin; v.chain = chain;
    v.e_data = d; v.e_carry = c; v.e_err = e;
    return v;
  endfunction

  // Starts and ends on a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input string name, input vec_t v, output int acc_wait);
    exp_t e;
    logic exp_cin;
    bus.cmd_valid = 1'b1; bus.cmd_op = v.op; bus.cmd_a = v.a; bus.cmd_b = v.b;
    bus.cmd_cin = v.cin; bus.cmd_chain = v.chain;
    e.data = v.e_data; e.carry = v.e_carry; e.err = v.e_err;
    sb_q.push_back(e);
    exp_cin = v.op & (v.chain ? tb_cc : v.cin);
    acc_wait = 0;
    while (!bus.cmd_ready && acc_wait < 50) begin
      @(negedge clk);
      acc_wait++;
    end
    check({name, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check({name, "_load_vld_in"}, 32'(bus.fa_vld_in), 1);
    check({name, "_load_ex"}, 32'(bus.fa_ex), 0);
    check({name, "_load_cin"}, 32'(bus.fa_carry_in), 32'(exp_cin));
    check({name, "_load_op"}, 32'(bus.fa_op), 32'(v.op));
    if (!v.e_err) tb_cc = v.op ? v.e_carry : 1'b0;
  endtask

  task automatic collect(input string name, output int lat);
    exp_t e;
    lat = 0;
    ex_ex = 1'b0;
    while (!bus.rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
      if (lat == 1) ex_ex = bus.fa_ex;
    end
    check({name, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
    check({name, "_exec_ex"}, 32'(ex_ex), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({name, "_data"}, 32'(bus.rsp_data), 32'(e.data));
      check({name, "_carry"}, 32'(bus.rsp_carry), 32'(e.carry));
      check({name, "_err"}, 32'(bus.rsp_err), 32'(e.err));
    end
  endtask

  task automatic complete(input string name);
    @(negedge clk);
    n_rsp++;
    check({name, "_op_count"}, 32'(bus.op_count), 32'(n_rsp));
    check({name, "_rsp_drop"}, 32'(bus.rsp_valid), 0);
    check({name, "_cmd_ready_back"}, 32'(bus.cmd_ready), 1);
  endtask

  task automatic run_vec(input string name, input vec_t v, input int exp_lat);
    int w, lat;
    issue(name, v, w);
    collect(name, lat);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    complete(name);
  endtask

  function automatic logic [31:0] idle_bits();
    return 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_err,
                bus.fa_op, bus.fa_ex, bus.fa_vld_in, bus.fa_carry_in});
  endfunction

  vec_t vecs[13];

  initial begin
    int w, lat;
    vecs[0]  = mk(1'b1, 8'h3C, 8'h0A, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[2]  = mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0, 8'h05, 8'h07, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 8'h10, 8'h10, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 8'h33, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 8'hC8, 8'h64, 1'b1, 1'b0, 8'h2D, 1'b1, 1'b0);
    vecs[10] = mk(1'b1, 8'h01, 8'hFE, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    vecs[11] = mk(1'b0, 8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.cmd_cin = 1'b0; bus.cmd_chain = 1'b0; bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_outputs", idle_bits(), 0);
    check("reset_op_count", 32'(bus.op_count), 0);
    check("reset_operands", 32'({bus.fa_op_a, bus.fa_op_b}), 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("release_cmd_ready", 32'(bus.cmd_ready), 1);

    for (int i = 0; i < 13; i++) run_vec($sformatf("v%0d", i), vecs[i], 3);

    // Backpressure: response held four cycles, then next command accepted right away.
    bus.rsp_ready = 1'b0;
    issue("bp", mk(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0), w);
    collect("bp", lat);
    check("bp_latency", 32'(lat), 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d_valid", i), 32'(bus.rsp_valid), 1);
      check($sformatf("bp_hold%0d_data", i), 32'(bus.rsp_data), 'h46);
      check($sformatf("bp_hold%0d_cmd_ready", i), 32'(bus.cmd_ready), 0);
      check($sformatf("bp_hold%0d_fa_idle", i), 32'({bus.fa_ex, bus.fa_vld_in}), 0);
    end
    bus.rsp_ready = 1'b1;
    complete("bp");
    issue("bp_next", mk(1'b0, 8'h09, 8'h03, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0), w);
    check("bp_next_accept_wait", 32'(w), 0);
    collect("bp_next", lat);
    complete("bp_next");

    // Timeout with a silent adder; chain carry set beforehand must survive it.
    run_vec("to_pre", mk(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0), 3);
    stub_dead = 1'b1;
    issue("to", mk(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1), w);
    collect("to", lat);
    check("to_latency", 32'(lat), TO + 3);
    complete("to");
    stub_dead = 1'b0;
    run_vec("to_chain", mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0), 3);

    // Reset during EXEC drops the command and clears chain carry and op_count.
    run_vec("rst_pre", mk(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0), 3);
    issue("rst_drop", mk(1'b1, 8'h05, 8'h05, 1'b0, 1'b0, 8'h0A, 1'b0, 1'b0), w);
    @(negedge clk);
    check("rst_in_exec", 32'(bus.fa_ex), 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_outputs", idle_bits(), 0);
    check("rst_op_count", 32'(bus.op_count), 0);
    check("rst_operands", 32'({bus.fa_op_a, bus.fa_op_b}), 0);
    reset_n = 1'b1;
    sb_q.delete();
    tb_cc = 1'b0;
    n_rsp = 0;
    @(negedge clk);
    check("rst_release_cmd_ready", 32'(bus.cmd_ready), 1);
    run_vec("rst_post", mk(1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0), 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
